// File: rtl/rtlola_param_queue.sv
// Parametrised shift-register FIFO for RTLola stream monitors; slot 0 holds the newest entry.
// Define RTLOLA_QUEUE_STATS_EN to add saturating drop/underflow counters.
module rtlola_param_queue #(
    parameter int WIDTH       = 64,
    parameter int DEPTH       = 5,
    parameter int DROP_OLDEST = 0,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     push,
    input  logic                     pop,
    input  logic signed [WIDTH-1:0]  data,
    output logic                     push_valid,
    output logic                     pop_valid,
    output logic signed [WIDTH-1:0]  out,
    output logic [DEPTH*WIDTH-1:0]   mem,
    output logic [CW-1:0]            cursor,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
`ifdef RTLOLA_QUEUE_STATS_EN
    ,
    output logic [15:0]              drop_cnt,
    output logic [15:0]              underflow_cnt
`endif
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [WIDTH-1:0] slot_d [DEPTH];
    logic [WIDTH-1:0] work   [DEPTH];
    logic [CW-1:0]    cursor_q, cursor_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             push_valid_q, push_valid_d;
    logic             pop_valid_q, pop_valid_d;
    logic             overflow_q, overflow_d;
    logic             do_pop, do_push;
    int               oldest;

    assign full  = (cursor_q == DEPTH_C);
    assign empty = (cursor_q == '0);

    // Pop clears the oldest slot first, then an accepted push shifts everything up by one.
    always_comb begin
        slot_d       = slot_q;
        work         = slot_q;
        cursor_d     = cursor_q;
        out_d        = out_q;
        push_valid_d = push_valid_q;
        pop_valid_d  = pop_valid_q;
        overflow_d   = overflow_q;
        do_pop       = 1'b0;
        do_push      = 1'b0;
        oldest       = int'(cursor_q) - 1;
        if (en) begin
            do_pop       = pop && !empty;
            do_push      = push && (!full || pop || (DROP_OLDEST != 0));
            overflow_d   = push && full && !pop;
            push_valid_d = do_push;
            pop_valid_d  = do_pop;
            out_d        = '0;
            if (do_pop) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == oldest) begin
                        out_d   = slot_q[i];
                        work[i] = '0;
                    end
                end
            end
            slot_d = work;
            if (do_push) begin
                slot_d[0] = data;
                for (int i = 1; i < DEPTH; i++) begin
                    slot_d[i] = work[i-1];
                end
            end
            if (do_push && !do_pop && !full) begin
                cursor_d = cursor_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cursor_d = cursor_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            cursor_q     <= '0;
            out_q        <= '0;
            push_valid_q <= 1'b0;
            pop_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            cursor_q     <= cursor_d;
            out_q        <= out_d;
            push_valid_q <= push_valid_d;
            pop_valid_q  <= pop_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_mem
        assign mem[g*WIDTH +: WIDTH] = slot_q[g];
    end

    assign cursor     = cursor_q;
    assign out        = out_q;
    assign push_valid = push_valid_q;
    assign pop_valid  = pop_valid_q;
    assign overflow   = overflow_q;

`ifdef RTLOLA_QUEUE_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] underflow_cnt_q, underflow_cnt_d;

    // A push+pop on an empty queue refills it, so it is not an underflow.
    always_comb begin
        drop_cnt_d      = drop_cnt_q;
        underflow_cnt_d = underflow_cnt_q;
        if (en && push && full && !pop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (en && pop && empty && !push && (underflow_cnt_q != 16'hFFFF)) begin
            underflow_cnt_d = underflow_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q      <= '0;
            underflow_cnt_q <= '0;
        end else begin
            drop_cnt_q      <= drop_cnt_d;
            underflow_cnt_q <= underflow_cnt_d;
        end
    end

    assign drop_cnt      = drop_cnt_q;
    assign underflow_cnt = underflow_cnt_q;
`endif

endmodule

// File: tb/tb_rtlola_param_queue.sv
// Directed testbench for rtlola_param_queue: one reject-policy and one drop-oldest instance share stimulus.
module tb_rtlola_param_queue;

    localparam int WIDTH = 64;
    localparam int DEPTH = 5;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     en;
    logic                     push;
    logic                     pop;
    logic signed [WIDTH-1:0]  data;

    logic                     rejPushValid, rejPopValid, rejFull, rejEmpty, rejOverflow;
    logic signed [WIDTH-1:0]  rejOut;
    logic [DEPTH*WIDTH-1:0]   rejMem;
    logic [CW-1:0]            rejCursor;

    logic                     dropPushValid, dropPopValid, dropFull, dropEmpty, dropOverflow;
    logic signed [WIDTH-1:0]  dropOut;
    logic [DEPTH*WIDTH-1:0]   dropMem;
    logic [CW-1:0]            dropCursor;

`ifdef RTLOLA_QUEUE_STATS_EN
    logic [15:0] rejDropCnt, rejUnderflowCnt, dropDropCnt, dropUnderflowCnt;
`endif

    int vectorCount   = 0;
    int miscompareCnt = 0;

    always #5 clk = ~clk;

    rtlola_param_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DROP_OLDEST(0)) uRej (
        .clk(clk), .rst(rst), .en(en), .push(push), .pop(pop), .data(data),
        .push_valid(rejPushValid), .pop_valid(rejPopValid), .out(rejOut), .mem(rejMem),
        .cursor(rejCursor), .full(rejFull), .empty(rejEmpty), .overflow(rejOverflow)
`ifdef RTLOLA_QUEUE_STATS_EN
        , .drop_cnt(rejDropCnt), .underflow_cnt(rejUnderflowCnt)
`endif
    );

    rtlola_param_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DROP_OLDEST(1)) uDrop (
        .clk(clk), .rst(rst), .en(en), .push(push), .pop(pop), .data(data),
        .push_valid(dropPushValid), .pop_valid(dropPopValid), .out(dropOut), .mem(dropMem),
        .cursor(dropCursor), .full(dropFull), .empty(dropEmpty), .overflow(dropOverflow)
`ifdef RTLOLA_QUEUE_STATS_EN
        , .drop_cnt(dropDropCnt), .underflow_cnt(dropUnderflowCnt)
`endif
    );

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic r, input logic e, input logic pu, input logic po,
                                 input logic [WIDTH-1:0] d);
        @(negedge clk);
        rst  = r;
        en   = e;
        push = pu;
        pop  = po;
        data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, $signed(observed), $signed(expected));
        end
    endtask

    function automatic logic [WIDTH-1:0] rejSlot(input int i);
        return rejMem[i*WIDTH +: WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] dropSlot(input int i);
        return dropMem[i*WIDTH +: WIDTH];
    endfunction

    task automatic checkRejSlots(input string tag, input logic [WIDTH-1:0] s0, input logic [WIDTH-1:0] s1,
                                 input logic [WIDTH-1:0] s2, input logic [WIDTH-1:0] s3,
                                 input logic [WIDTH-1:0] s4);
        checkOutput({tag, "_s0"}, rejSlot(0), s0);
        checkOutput({tag, "_s1"}, rejSlot(1), s1);
        checkOutput({tag, "_s2"}, rejSlot(2), s2);
        checkOutput({tag, "_s3"}, rejSlot(3), s3);
        checkOutput({tag, "_s4"}, rejSlot(4), s4);
    endtask

    task automatic checkRejOutputs(input string tag, input logic pv, input logic ppv, input logic [WIDTH-1:0] o);
        checkOutput({tag, "_push_valid"}, 64'(rejPushValid), 64'(pv));
        checkOutput({tag, "_pop_valid"}, 64'(rejPopValid), 64'(ppv));
        checkOutput({tag, "_out"}, rejOut, o);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; push = 1'b0; pop = 1'b0; data = '0;

        // Reset state
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("rst_cursor", 64'(rejCursor), 64'd0);
        checkOutput("rst_empty", 64'(rejEmpty), 64'd1);
        checkOutput("rst_full", 64'(rejFull), 64'd0);
        checkRejOutputs("rst", 0, 0, 0);
        checkOutput("rst_overflow", 64'(rejOverflow), 64'd0);

        // Push 1,2,3 then pop the oldest
        applyStimulus(0, 1, 1, 0, 1);
        checkOutput("t1_push_valid", 64'(rejPushValid), 64'd1);
        applyStimulus(0, 1, 1, 0, 2);
        applyStimulus(0, 1, 1, 0, 3);
        checkOutput("t1_cursor3", 64'(rejCursor), 64'd3);
        checkRejSlots("t1_push", 3, 2, 1, 0, 0);
        applyStimulus(0, 1, 0, 1, 0);
        checkRejOutputs("t1_pop", 0, 1, 1);
        checkRejSlots("t1_pop", 3, 2, 0, 0, 0);
        checkOutput("t1_cursor2", 64'(rejCursor), 64'd2);

        // Simultaneous push+pop keeps the cursor
        applyStimulus(0, 1, 1, 1, 4);
        checkRejOutputs("t2_pp4", 1, 1, 2);
        checkOutput("t2_cursor_a", 64'(rejCursor), 64'd2);
        applyStimulus(0, 1, 1, 1, 5);
        checkRejOutputs("t2_pp5", 1, 1, 3);
        checkOutput("t2_cursor_b", 64'(rejCursor), 64'd2);
        checkRejSlots("t2", 5, 4, 0, 0, 0);

        // Empty-queue handling
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 7);
        checkRejOutputs("t3_pp_empty", 1, 0, 0);
        checkOutput("t3_cursor1", 64'(rejCursor), 64'd1);
        applyStimulus(0, 1, 0, 1, 0);
        checkRejOutputs("t3_pop7", 0, 1, 7);
        checkOutput("t3_empty", 64'(rejEmpty), 64'd1);
        applyStimulus(0, 1, 0, 1, 0);
        checkRejOutputs("t3_pop_under_a", 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0);
        checkRejOutputs("t3_pop_under_b", 0, 0, 0);
        checkOutput("t3_cursor0", 64'(rejCursor), 64'd0);
`ifdef RTLOLA_QUEUE_STATS_EN
        checkOutput("t3_underflow_cnt", 64'(rejUnderflowCnt), 64'd2);
`endif
        applyStimulus(0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFD);
        checkOutput("t3_signed_slot0", rejSlot(0), 64'hFFFF_FFFF_FFFF_FFFD);
        applyStimulus(0, 1, 0, 0, 0);
        checkRejOutputs("t3_idle", 0, 0, 0);

        // Reject policy on a full queue
        applyStimulus(1, 1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) applyStimulus(0, 1, 1, 0, 64'(i));
        checkOutput("t4_full", 64'(rejFull), 64'd1);
        applyStimulus(0, 1, 1, 0, 6);
        checkOutput("t4_push_valid", 64'(rejPushValid), 64'd0);
        checkOutput("t4_overflow", 64'(rejOverflow), 64'd1);
        checkRejSlots("t4_rej", 5, 4, 3, 2, 1);
        checkOutput("t4_cursor5", 64'(rejCursor), 64'd5);
        applyStimulus(0, 1, 1, 1, 9);
        checkRejOutputs("t4_pp9", 1, 1, 1);
        checkOutput("t4_pp_overflow", 64'(rejOverflow), 64'd0);
        checkRejSlots("t4_pp", 9, 5, 4, 3, 2);

        // Drop-oldest policy on a full queue
        applyStimulus(1, 1, 0, 0, 0);
        for (int i = 1; i <= 6; i++) applyStimulus(0, 1, 1, 0, 64'(i));
        checkOutput("t5_push_valid", 64'(dropPushValid), 64'd1);
        checkOutput("t5_overflow", 64'(dropOverflow), 64'd1);
        checkOutput("t5_cursor5", 64'(dropCursor), 64'd5);
        checkOutput("t5_s0", dropSlot(0), 64'd6);
        checkOutput("t5_s1", dropSlot(1), 64'd5);
        checkOutput("t5_s2", dropSlot(2), 64'd4);
        checkOutput("t5_s3", dropSlot(3), 64'd3);
        checkOutput("t5_s4", dropSlot(4), 64'd2);
`ifdef RTLOLA_QUEUE_STATS_EN
        checkOutput("t5_drop_cnt", 64'(dropDropCnt), 64'd1);
`endif

        // Clock enable freezes everything; reset still wins
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 1);
        applyStimulus(0, 1, 1, 0, 2);
        applyStimulus(0, 0, 1, 0, 8);
        checkOutput("t6_hold_cursor", 64'(rejCursor), 64'd2);
        checkOutput("t6_hold_push_valid", 64'(rejPushValid), 64'd1);
        checkRejSlots("t6_hold", 2, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t6_rst_cursor", 64'(rejCursor), 64'd0);
        checkOutput("t6_rst_push_valid", 64'(rejPushValid), 64'd0);
        checkRejSlots("t6_rst", 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCnt);
        $finish;
    end

endmodule
